pb_key_fifo: RTL and testbench
==============================

# pb_key_fifo

Upstream input conditioner for the memory-mapped I/O page. Takes the 21 raw FPGA pushbuttons, synchronizes and debounces them, and turns each debounced press into a 5-bit key code. Codes are queued in a small FIFO that the I/O driver pops when the CPU reads the keypad address. The FIFO gives software one clean event per press, with no polling races and no bounce.

## Interface
Parameters:
- NUM_PB, 21: number of pushbuttons (max 31; code 31 reserved).
- TICK_DIV, 10000: clk cycles per debounce sample tick (≥2).
- STABLE_SAMPLES, 4: consecutive disagreeing samples needed to flip a debounced level (1–15).
- FIFO_DEPTH, 4: key FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset. One clock; reset is asynchronous and active-low.
- pb_raw  in  NUM_PB  raw asynchronous button levels, 1 = pressed.
- pop  in  1  single-cycle strobe from the I/O driver; removes the head entry.
- ovr_clr  in  1  clears key_overrun.
- pb_clean  out  NUM_PB  debounced levels.
- key_code  out  5  head-of-FIFO code; 5'h1F when empty.
- key_empty  out  1  FIFO empty.
- key_count  out  $clog2(FIFO_DEPTH)+1  number of entries.
- key_overrun  out  1  sticky; a press was dropped.

## Operation
- Synchronizer: two-flop synchronizer per bit, giving pb_sync.
- Tick generator: counter runs 0..TICK_DIV-1 and wraps. tick=1 for the one cycle when counter==TICK_DIV-1.
- Debounce, per button, evaluated on tick only:
  - If pb_sync != pb_clean, increment the agreement counter.
  - When the counter reaches STABLE_SAMPLES, toggle pb_clean and zero the counter.
  - If pb_sync == pb_clean, zero the counter.
- Press detect: pb_prev is a registered copy of pb_clean. rise = pb_clean & ~pb_prev. Releases generate no event.
- Encoding:
  - If any rise bit is set, the lowest set index is pushed as the key code.
  - All other simultaneous rises are dropped and set key_overrun.
- FIFO behaviour:
  - Push when full without pop: entry dropped, key_overrun set.
  - Push and pop in the same cycle when full: both happen, count unchanged, new code written at the tail.
  - Push and pop in the same cycle when empty: the push happens and the pop is ignored. The code appears next cycle.
  - Pop when empty: ignored, no error.
- Pointers: wrap modulo FIFO_DEPTH. key_count is the separate occupancy counter, 0..FIFO_DEPTH.
- key_overrun:
  - ovr_clr takes priority over a set in the same cycle. The flag stays clear and the dropped event is lost.

## Timing
- Reset values:
  - pb_clean=0, key_empty=1, key_code=5'h1F, key_count=0, key_overrun=0.
  - Synchronizers, tick counter, debounce counters, pb_prev and pointers all 0.
- Raw edge to pb_clean: 2 cycles sync, then STABLE_SAMPLES to STABLE_SAMPLES+1 ticks.
- pb_clean rise to FIFO entry: 2 cycles. pb_prev compare is 1 cycle, push write is 1 cycle. key_empty falls on the second edge.
- key_code, key_empty and key_count are registered outputs. key_code is the head entry, updated the cycle after pop.
- nrst asserted mid-debounce or with the FIFO non-empty: everything returns to reset values immediately. Held buttons re-register as presses after reset release plus debounce latency.

## Configuration
- PB_DEBOUNCE_EN defined: debounce as above.
- PB_DEBOUNCE_EN undefined:
  - Tick generator and debounce counters are removed; pb_clean = pb_sync, registered.
  - STABLE_SAMPLES and TICK_DIV are ignored.
  - Used for simulation speed and for boards with hardware-debounced buttons.

## Structure
- Package pb_pkg holds:
  - NUM_PB_DEFAULT = 21.
  - KEY_W = 5.
  - KEY_NONE = 5'h1F.
  - typedef logic [KEY_W-1:0] key_code_t.
- Sub-module pb_debounce_cell: one button's counter and level, taking sample/tick and giving clean. It is instantiated NUM_PB times in a generate loop, and only under PB_DEBOUNCE_EN.
- FIFO, encoder and edge detect stay inline.

## Test plan
Bench runs with TICK_DIV=4, STABLE_SAMPLES=3, FIFO_DEPTH=4, PB_DEBOUNCE_EN defined.
- Bounce: pb_raw[5] toggles every 3 cycles for 40 cycles, then holds 1 -> exactly one entry, key_code=5, key_count=1; no entry on release.
- Simultaneous press: pb_raw[2] and pb_raw[9] rise in the same cycle -> one entry, code 2, key_overrun=1; ovr_clr clears it next cycle.
- Overflow: five distinct presses (codes 1,3,4,6,7), no pops -> key_count=4, FIFO holds 1,3,4,6, key_overrun=1. Four pops yield 1,3,4,6, then key_empty=1 and key_code=5'h1F.
- Full with push and pop together: FIFO full, pop coincides with the push of code 8 -> key_count stays 4, head advances, 8 is last out.
- Empty pop, then reset: pop with FIFO empty -> no change. Assert nrst with 2 entries queued -> all outputs return to reset values asynchronously.
- Bypass build (PB_DEBOUNCE_EN undefined): a 1-cycle pb_raw[0] pulse -> entry code 0 appears 4 cycles after the pulse.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared types and constants for the pushbutton key FIFO.
package pb_pkg;
    localparam int NUM_PB_DEFAULT = 21;
    localparam int KEY_W          = 5;
    typedef logic [KEY_W-1:0] key_code_t;
    localparam key_code_t KEY_NONE = 5'h1F;
endpackage

// File: rtl/pb_debounce_cell.sv
// Single-button debouncer: flips its level after STABLE_SAMPLES consecutive
// disagreeing samples taken on tick.
module pb_debounce_cell #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic tick_i,
    input  logic sample_i,
    output logic clean_o
);
    logic [3:0] cnt_q, cnt_d;
    logic       clean_q, clean_d;

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (tick_i) begin
            if (sample_i != clean_q) begin
                if (cnt_q == 4'(STABLE_SAMPLES - 1)) begin
                    clean_d = ~clean_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o = clean_q;
endmodule

// File: rtl/pb_key_fifo.sv
// Pushbutton synchronizer/debouncer, press encoder and key-code FIFO.
// Define PB_DEBOUNCE_EN for tick-based debounce; otherwise pb_clean follows the synchronizer.
module pb_key_fifo
    import pb_pkg::*;
#(
    parameter int NUM_PB         = NUM_PB_DEFAULT,
    parameter int TICK_DIV       = 10000,
    parameter int STABLE_SAMPLES = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [NUM_PB-1:0]             pb_raw,
    input  logic                          pop,
    input  logic                          ovr_clr,
    output logic [NUM_PB-1:0]             pb_clean,
    output logic [KEY_W-1:0]              key_code,
    output logic                          key_empty,
    output logic [$clog2(FIFO_DEPTH):0]   key_count,
    output logic                          key_overrun
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [NUM_PB-1:0] sync1_q, sync2_q, pb_prev_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pb_prev_q <= '0;
        end else begin
            sync1_q   <= pb_raw;
            sync2_q   <= sync1_q;
            pb_prev_q <= pb_clean;
        end
    end

`ifdef PB_DEBOUNCE_EN
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [TW-1:0] tick_q;
    logic          tick;

    assign tick = (tick_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) tick_q <= '0;
        else       tick_q <= tick ? '0 : tick_q + TW'(1);
    end

    for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_db
        pb_debounce_cell #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_cell (
            .clk      (clk),
            .nrst     (nrst),
            .tick_i   (tick),
            .sample_i (sync2_q[gi]),
            .clean_o  (pb_clean[gi])
        );
    end
`else
    assign pb_clean = sync2_q;
`endif

    // Lowest pressed index wins; any other simultaneous press is an overrun.
    logic [NUM_PB-1:0] rise;
    key_code_t         enc_code;
    logic              enc_hit, enc_multi;

    assign rise      = pb_clean & ~pb_prev_q;
    assign enc_multi = |(rise & (rise - NUM_PB'(1)));

    always_comb begin
        enc_code = KEY_NONE;
        enc_hit  = 1'b0;
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (rise[i]) begin
                enc_code = key_code_t'(i);
                enc_hit  = 1'b1;
            end
        end
    end

    logic      push_q, multi_q;
    key_code_t push_code_q;
    key_code_t mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    key_code_t     key_code_q, key_code_d;
    logic          empty_q, ovr_q, ovr_d;
    logic          do_push, do_pop, full;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push_q && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        ovr_d    = ovr_q | multi_q | (push_q && !do_push);
        if (ovr_clr) ovr_d = 1'b0;
        // The new head can be the entry being written this very cycle.
        if (count_d == '0)
            key_code_d = KEY_NONE;
        else if (count_q == '0 || (do_pop && count_q == CW'(1)))
            key_code_d = push_code_q;
        else
            key_code_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            push_q     <= 1'b0;
            multi_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            key_code_q <= KEY_NONE;
            empty_q    <= 1'b1;
            ovr_q      <= 1'b0;
        end else begin
            push_q     <= enc_hit;
            multi_q    <= enc_multi;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            key_code_q <= key_code_d;
            empty_q    <= (count_d == '0);
            ovr_q      <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        push_code_q <= enc_code;
        if (do_push) mem_q[wr_ptr_q] <= push_code_q;
    end

    assign key_code    = key_code_q;
    assign key_empty   = empty_q;
    assign key_count   = count_q;
    assign key_overrun = ovr_q;
endmodule

// File: tb/tb_pb_key_fifo.sv
// Directed bench for pb_key_fifo; adapts to whether PB_DEBOUNCE_EN is defined.
module tb_pb_key_fifo;
    localparam int NUM_PB = 21;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic [NUM_PB-1:0] pb_raw = '0;
    logic              pop = 1'b0;
    logic              ovr_clr = 1'b0;
    logic [NUM_PB-1:0] pb_clean;
    logic [4:0]        key_code;
    logic              key_empty;
    logic [2:0]        key_count;
    logic              key_overrun;

    int n_checks = 0;
    int n_errors = 0;

    pb_key_fifo #(
        .NUM_PB(NUM_PB), .TICK_DIV(4), .STABLE_SAMPLES(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .nrst(nrst), .pb_raw(pb_raw), .pop(pop), .ovr_clr(ovr_clr),
        .pb_clean(pb_clean), .key_code(key_code), .key_empty(key_empty),
        .key_count(key_count), .key_overrun(key_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        cyc(1);
        pop = 1'b0;
    endtask

    task automatic tap(input int idx);
        pb_raw[idx] = 1'b1;
        cyc(30);
        pb_raw[idx] = 1'b0;
        cyc(30);
    endtask

    initial begin
        int n;
        int exp_codes[4];
        cyc(3);
        check("rst_clean", 32'(pb_clean), 0);
        check("rst_empty", 32'(key_empty), 1);
        check("rst_code", 32'(key_code), 32'h1F);
        check("rst_count", 32'(key_count), 0);
        check("rst_ovr", 32'(key_overrun), 0);
        nrst = 1'b1;
        cyc(2);

`ifdef PB_DEBOUNCE_EN
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pb_raw[5] = ~pb_raw[5];
            cyc(1);
        end
        check("bounce_none", 32'(key_count), 0);
        pb_raw[5] = 1'b1;
        cyc(30);
        check("bounce_clean", 32'(pb_clean[5]), 1);
        check("bounce_count", 32'(key_count), 1);
        check("bounce_code", 32'(key_code), 5);
        pb_raw[5] = 1'b0;
        cyc(30);
        check("release_count", 32'(key_count), 1);
        do_pop();
`else
        pb_raw[0] = 1'b1;
        cyc(1);
        pb_raw[0] = 1'b0;
        n = 1;
        while (key_empty && n < 10) begin
            cyc(1);
            n++;
        end
        check("bypass_lat", 32'(n), 4);
        check("bypass_code", 32'(key_code), 0);
        cyc(10);
        do_pop();
`endif
        check("pop_empty", 32'(key_empty), 1);

        pb_raw[2] = 1'b1;
        pb_raw[9] = 1'b1;
        cyc(30);
        check("simul_count", 32'(key_count), 1);
        check("simul_code", 32'(key_code), 2);
        check("simul_ovr", 32'(key_overrun), 1);
        ovr_clr = 1'b1;
        cyc(1);
        ovr_clr = 1'b0;
        check("ovr_clr", 32'(key_overrun), 0);
        pb_raw[2] = 1'b0;
        pb_raw[9] = 1'b0;
        cyc(30);
        do_pop();

        tap(1); tap(3); tap(4); tap(6); tap(7);
        check("ovf_count", 32'(key_count), 4);
        check("ovf_ovr", 32'(key_overrun), 1);
        exp_codes = '{1, 3, 4, 6};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_head%0d", i), 32'(key_code), 32'(exp_codes[i]));
            do_pop();
        end
        check("ovf_empty", 32'(key_empty), 1);
        check("ovf_none", 32'(key_code), 32'h1F);
        ovr_clr = 1'b1;
        cyc(1);
        ovr_clr = 1'b0;

        tap(10); tap(11); tap(12); tap(13);
        check("full_count", 32'(key_count), 4);
        pb_raw[8] = 1'b1;
        n = 0;
        while (!pb_clean[8] && n < 60) begin
            cyc(1);
            n++;
        end
        check("full_wait", 32'(pb_clean[8]), 1);
        cyc(1);
        pop = 1'b1;
        cyc(1);
        pop = 1'b0;
        check("pp_count", 32'(key_count), 4);
        check("pp_head", 32'(key_code), 11);
        check("pp_ovr", 32'(key_overrun), 0);
        exp_codes = '{11, 12, 13, 8};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_out%0d", i), 32'(key_code), 32'(exp_codes[i]));
            do_pop();
        end
        pb_raw[8] = 1'b0;
        cyc(30);

        do_pop();
        check("epop_count", 32'(key_count), 0);
        check("epop_empty", 32'(key_empty), 1);
        check("epop_code", 32'(key_code), 32'h1F);
        check("epop_ovr", 32'(key_overrun), 0);

        tap(14);
        pb_raw[15] = 1'b1;
        cyc(30);
        check("pre_rst_count", 32'(key_count), 2);
        nrst = 1'b0;
        #2;
        check("arst_count", 32'(key_count), 0);
        check("arst_empty", 32'(key_empty), 1);
        check("arst_code", 32'(key_code), 32'h1F);
        check("arst_clean", 32'(pb_clean), 0);
        cyc(2);
        nrst = 1'b1;
        cyc(30);
        check("rereg_count", 32'(key_count), 1);
        check("rereg_code", 32'(key_code), 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
